// File: rtl/brick_pkg.sv
// Shared definitions for the brick map engine: map-port function codes,
// default grid geometry and the brick kind width.
package brick_pkg;

  localparam int DEF_ROWS = 24;
  localparam int DEF_COLS = 32;
  localparam int KIND_W   = 3;
  localparam int ADDR_W   = 7;
  localparam int SCORE_W  = 16;
  localparam int REM_W    = 10;

  typedef enum logic [1:0] {
    BLK_CLEAR = 2'b00,
    BLK_LOAD  = 2'b01,
    BLK_DROP  = 2'b10,
    BLK_PULL  = 2'b11
  } blk_func_e;

  typedef logic [KIND_W-1:0] kind_t;

  // Score accumulation clamps at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add_score(input logic [SCORE_W-1:0] a,
                                                       input kind_t            b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {{(SCORE_W+1-KIND_W){1'b0}}, b};
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/brick_cursor.sv
// Row/column walk used by the level fill: clear to (0,0), advance column-first
// with wrap into the next row, hold when not advancing.
module brick_cursor
  import brick_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int LAST_ROW = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] row_o,
  output logic [ADDR_W-1:0] col_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic              col_wrap;

  assign col_wrap = (col_q == ADDR_W'(COLS - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = row_q + ADDR_W'(1);
      end else begin
        col_d = col_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = col_wrap && (row_q == ADDR_W'(LAST_ROW));

endmodule

// File: rtl/brick_hit_engine.sv
// Brick map engine: level fill and single-cell hit query/clear over a
// brick-map master port. Define BRICK_HARDNESS_EN to make kind-7 bricks
// degrade to kind 6 on a hit instead of being cleared.
module brick_hit_engine
  import brick_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int FILL_ROWS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fill_start_i,
  input  logic               hit_req_i,
  input  logic [ADDR_W-1:0]  hit_row_i,
  input  logic [ADDR_W-1:0]  hit_col_i,
  output logic               hit_done_o,
  output logic [KIND_W-1:0]  hit_kind_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [REM_W-1:0]   remaining_o,
  output logic               busy_o,
  output logic               blk_enable_o,
  output logic [1:0]         blk_func_o,
  output logic [ADDR_W-1:0]  blk_row_o,
  output logic [ADDR_W-1:0]  blk_col_o,
  output logic [KIND_W-1:0]  blk_in_o,
  input  logic [KIND_W-1:0]  blk_out_i,
  input  logic               blk_busy_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_HIT_RD,
    S_HIT_WAIT,
    S_HIT_WR,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  hrow_q, hcol_q;
  kind_t              kind_q;
  logic [SCORE_W-1:0] score_q;
  logic [REM_W-1:0]   rem_q;

  logic [ADDR_W-1:0]  cur_row, cur_col, row_mod;
  logic               cur_last, cur_clr;
  logic               fill_go, wr_go, in_range, hard_hit;
  kind_t              fill_kind;

  assign fill_go  = (state_q == S_FILL)   && !blk_busy_i;
  assign wr_go    = (state_q == S_HIT_WR) && !blk_busy_i;
  assign cur_clr  = (state_q == S_IDLE)   && fill_start_i;
  assign in_range = (hit_row_i < ADDR_W'(ROWS)) && (hit_col_i < ADDR_W'(COLS));

`ifdef BRICK_HARDNESS_EN
  assign hard_hit = (kind_q == KIND_W'(7));
`else
  assign hard_hit = 1'b0;
`endif

  brick_cursor #(
    .COLS     (COLS),
    .LAST_ROW (FILL_ROWS - 1)
  ) u_cursor (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cur_clr),
    .adv_i  (fill_go),
    .row_o  (cur_row),
    .col_o  (cur_col),
    .last_o (cur_last)
  );

  // Fill pattern cycles kinds 1..7 down the rows.
  assign row_mod   = cur_row % ADDR_W'(7);
  assign fill_kind = KIND_W'(row_mod + ADDR_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hrow_q  <= '0;
      hcol_q  <= '0;
      kind_q  <= '0;
      score_q <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fill_start_i) begin
            rem_q   <= '0;
            state_q <= S_FILL;
          end else if (hit_req_i) begin
            hrow_q  <= hit_row_i;
            hcol_q  <= hit_col_i;
            kind_q  <= '0;
            state_q <= in_range ? S_HIT_RD : S_DONE;
          end
        end
        S_FILL: begin
          if (!blk_busy_i) begin
            rem_q <= rem_q + REM_W'(1);
            if (cur_last) state_q <= S_IDLE;
          end
        end
        S_HIT_RD:   state_q <= S_HIT_WAIT;
        S_HIT_WAIT: begin
          kind_q  <= blk_out_i;
          state_q <= (blk_out_i == '0) ? S_DONE : S_HIT_WR;
        end
        S_HIT_WR: begin
          if (!blk_busy_i) begin
            score_q <= sat_add_score(score_q, kind_q);
            if (!hard_hit && rem_q != '0) rem_q <= rem_q - REM_W'(1);
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Map port is decoded straight from state flops so blk_busy can gate it in-cycle.
  always_comb begin
    blk_func_o = BLK_CLEAR;
    blk_in_o   = '0;
    blk_row_o  = hrow_q;
    blk_col_o  = hcol_q;
    if (state_q == S_FILL) begin
      blk_func_o = BLK_LOAD;
      blk_in_o   = fill_kind;
      blk_row_o  = cur_row;
      blk_col_o  = cur_col;
    end else if (state_q == S_HIT_WR && hard_hit) begin
      blk_func_o = BLK_LOAD;
      blk_in_o   = KIND_W'(6);
    end
  end

  assign blk_enable_o = fill_go || wr_go;
  assign busy_o       = (state_q != S_IDLE);
  assign hit_done_o   = (state_q == S_DONE);
  assign hit_kind_o   = kind_q;
  assign score_o      = score_q;
  assign remaining_o  = rem_q;

endmodule

// File: tb/tb_brick_hit_engine.sv
// Randomized bench for brick_hit_engine with a grid-level reference model
// and an attached brick-map memory.
module tb_brick_hit_engine;
  import brick_pkg::*;

  localparam int ROWS      = 24;
  localparam int COLS      = 32;
  localparam int FILL_ROWS = 8;
`ifdef BRICK_HARDNESS_EN
  localparam bit HARD = 1'b1;
`else
  localparam bit HARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fill_start_i, hit_req_i;
  logic [6:0]  hit_row_i, hit_col_i;
  logic        hit_done_o, busy_o, blk_enable_o, blk_busy_i;
  logic [2:0]  hit_kind_o, blk_in_o, blk_out_i;
  logic [15:0] score_o;
  logic [9:0]  remaining_o;
  logic [1:0]  blk_func_o;
  logic [6:0]  blk_row_o, blk_col_o;

  always #5 clk = ~clk;

  brick_hit_engine #(.ROWS(ROWS), .COLS(COLS), .FILL_ROWS(FILL_ROWS)) dut (
    .clk(clk), .rst_n(rst_n),
    .fill_start_i(fill_start_i), .hit_req_i(hit_req_i),
    .hit_row_i(hit_row_i), .hit_col_i(hit_col_i),
    .hit_done_o(hit_done_o), .hit_kind_o(hit_kind_o), .score_o(score_o),
    .remaining_o(remaining_o), .busy_o(busy_o),
    .blk_enable_o(blk_enable_o), .blk_func_o(blk_func_o),
    .blk_row_o(blk_row_o), .blk_col_o(blk_col_o), .blk_in_o(blk_in_o),
    .blk_out_i(blk_out_i), .blk_busy_i(blk_busy_i)
  );

  typedef struct {
    logic [1:0] f;
    int         r;
    int         c;
    logic [2:0] v;
  } wr_t;

  int         n_cmp = 0, n_bad = 0, n_wr = 0;
  logic [2:0] env_map [ROWS][COLS];
  logic [2:0] ref_map [ROWS][COLS];
  wr_t        exp_q[$];
  int         m_score, m_rem, m_kind;
  bit         chk_en = 0, stall_mode = 0, force_busy = 0;

  function automatic logic [2:0] init_val(input int r, input int c);
    if (r < FILL_ROWS || (r == 20 && c == 5)) return 3'd0;
    return 3'((r * 5 + c * 3) % 8);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Brick-map memory: combinational read, writes land on the clock edge.
  initial begin
    int r, c;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) env_map[i][j] = init_val(i, j);
    forever begin
      @(posedge clk);
      r = int'(blk_row_o);
      c = int'(blk_col_o);
      if (rst_n && blk_enable_o && r < ROWS && c < COLS)
        env_map[r][c] = (blk_func_o == 2'b01) ? blk_in_o : 3'd0;
    end
  end

  always_comb begin
    blk_out_i = 3'd0;
    if (int'(blk_row_o) < ROWS && int'(blk_col_o) < COLS)
      blk_out_i = env_map[int'(blk_row_o)][int'(blk_col_o)];
  end

  initial begin
    blk_busy_i = 1'b0;
    forever begin
      @(posedge clk); #2;
      blk_busy_i = stall_mode ? ($urandom_range(0, 3) == 0) : force_busy;
    end
  end

  // Per-cycle compare: every map write against the expected queue, idle state against the model.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (blk_enable_o) begin
        n_wr++;
        check("en_with_map_busy", blk_busy_i, 0);
        check("en_while_active", busy_o, 1);
        check("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("wr_func", blk_func_o, w.f);
          check("wr_row", blk_row_o, w.r);
          check("wr_col", blk_col_o, w.c);
          if (w.f == 2'b01) check("wr_in", blk_in_o, w.v);
        end
      end
      if (chk_en) begin
        check("idle_score", score_o, m_score);
        check("idle_remaining", remaining_o, m_rem);
        check("idle_kind", hit_kind_o, m_kind);
        check("idle_busy", busy_o, 0);
        check("idle_done", hit_done_o, 0);
        check("idle_enable", blk_enable_o, 0);
      end
    end
  end

  task automatic run_op(input int stall_at, output int cyc, output int dones);
    cyc = 0;
    dones = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      fill_start_i = 1'b0;
      hit_req_i    = 1'b0;
      if (stall_at >= 0 && cyc == stall_at)      force_busy = 1'b1;
      if (stall_at >= 0 && cyc == stall_at + 10) force_busy = 1'b0;
      if (hit_done_o) dones++;
      if (!busy_o) break;
      cyc++;
    end
    force_busy = 1'b0;
    check("op_completes", busy_o, 0);
    chk_en = 1'b1;
  endtask

  task automatic predict_fill();
    for (int r = 0; r < FILL_ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        exp_q.push_back('{2'b01, r, c, 3'((r % 7) + 1)});
        ref_map[r][c] = 3'((r % 7) + 1);
      end
    m_rem = FILL_ROWS * COLS;
  endtask

  task automatic do_fill(input bit with_hit, input int stall_at);
    int cyc, dones, w0;
    chk_en = 1'b0;
    predict_fill();
    w0 = n_wr;
    fill_start_i = 1'b1;
    hit_req_i    = with_hit;
    hit_row_i    = 7'd3;
    hit_col_i    = 7'd5;
    run_op(stall_at, cyc, dones);
    check("fill_loads", n_wr - w0, FILL_ROWS * COLS);
    check("fill_queue_drained", exp_q.size(), 0);
    check("fill_no_done", dones, 0);
    if (!stall_mode) check("fill_cycles", cyc, FILL_ROWS * COLS + (stall_at >= 0 ? 10 : 0));
  endtask

  task automatic do_hit(input int r, input int c);
    int cyc, dones, w0, kind, exp_cyc;
    bit ok;
    chk_en = 1'b0;
    ok = (r < ROWS && c < COLS);
    kind = ok ? int'(ref_map[r][c]) : 0;
    exp_cyc = !ok ? 1 : (kind != 0 ? 4 : 3);
    if (kind != 0) begin
      if (HARD && kind == 7) begin
        exp_q.push_back('{2'b01, r, c, 3'd6});
        ref_map[r][c] = 3'd6;
      end else begin
        exp_q.push_back('{2'b00, r, c, 3'd0});
        ref_map[r][c] = 3'd0;
        if (m_rem > 0) m_rem--;
      end
      m_score = (m_score + kind > 65535) ? 65535 : m_score + kind;
    end
    m_kind = kind;
    w0 = n_wr;
    hit_req_i = 1'b1;
    hit_row_i = 7'(r);
    hit_col_i = 7'(c);
    run_op(-1, cyc, dones);
    check("hit_done_pulses", dones, 1);
    check("hit_writes", n_wr - w0, kind != 0);
    check("hit_queue_drained", exp_q.size(), 0);
    if (!stall_mode) check("hit_cycles", cyc, exp_cyc);
  endtask

  task automatic cmp_map(input string name);
    int diffs = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (env_map[r][c] !== ref_map[r][c]) diffs++;
    check(name, diffs, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    fill_start_i = 1'b0;
    hit_req_i = 1'b0;
    hit_row_i = '0;
    hit_col_i = '0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) ref_map[i][j] = init_val(i, j);
    m_score = 0; m_rem = 0; m_kind = 0;
    #12;
    check("reset_outputs", {blk_enable_o, blk_func_o, blk_row_o, blk_col_o, blk_in_o,
                            hit_done_o, hit_kind_o, score_o, remaining_o, busy_o}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    do_fill(1'b0, -1);
    check("lit_fill_remaining", remaining_o, 256);
    check("lit_row0_kind", env_map[0][0], 1);
    check("lit_row7_kind", env_map[7][31], 1);
    check("lit_row6_kind", env_map[6][10], 7);
    check("lit_cell_3_5", env_map[3][5], 4);

    do_hit(3, 5);
    check("lit_hit_kind", hit_kind_o, 4);
    check("lit_hit_score", score_o, 4);
    check("lit_hit_remaining", remaining_o, 255);
    check("lit_hit_cleared", env_map[3][5], 0);

    do_hit(20, 5);
    check("lit_empty_kind", hit_kind_o, 0);
    check("lit_empty_score", score_o, 4);
    check("lit_empty_remaining", remaining_o, 255);

    do_hit(30, 40);
    check("lit_oor_kind", hit_kind_o, 0);

    do_hit(6, 2);
    check("lit_k7_score", score_o, 11);
    check("lit_k7_cell", env_map[6][2], HARD ? 6 : 0);
    check("lit_k7_remaining", remaining_o, HARD ? 255 : 254);

    do_fill(1'b0, 100);
    do_fill(1'b1, -1);
    cmp_map("map_after_directed");

    stall_mode = 1'b1;
    for (int k = 0; k < 80; k++) begin
      int op, r, c;
      op = $urandom_range(0, 9);
      if (op == 0) do_fill(1'b0, -1);
      else begin
        r = (op < 6) ? $urandom_range(0, FILL_ROWS - 1) : $urandom_range(0, ROWS + 2);
        c = $urandom_range(0, COLS + 2);
        do_hit(r, c);
      end
    end
    stall_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_map("map_after_random");

    // Reset partway through a fill.
    chk_en = 1'b0;
    predict_fill();
    fill_start_i = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      fill_start_i = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    check("reset_midfill_outputs", {blk_enable_o, blk_func_o, blk_row_o, blk_col_o, blk_in_o,
                                    hit_done_o, hit_kind_o, score_o, remaining_o, busy_o}, 0);
    exp_q.delete();
    m_score = 0; m_rem = 0; m_kind = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("reset_not_resumed", busy_o, 0);

    do_hit(9, 0);
    check("lit_floor_kind", hit_kind_o, 5);
    check("lit_floor_score", score_o, 5);
    check("lit_floor_remaining", remaining_o, 0);
    do_fill(1'b0, -1);
    cmp_map("map_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/brick_hit_engine.md
BRICK_HIT_ENGINE -- requirements
Module: brick_hit_engine

Interface
REQ-001 SHALL have parameters: ROWS, default 24, grid rows; COLS, default 32, grid columns; FILL_ROWS, default 8, rows loaded by a level fill.
REQ-002 SHALL have ports: clock, input, 1, sole clock; all state on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-low.
REQ-004 SHALL have client ports: fill_start in 1, start level fill; hit_req in 1, hit query; hit_row in 7; hit_col in 7.
REQ-005 SHALL have result ports: hit_done out 1, one-cycle completion pulse; hit_kind out 3, kind found; score out 16; remaining out 10; busy out 1.
REQ-006 SHALL have brick-map master ports: blk_enable out 1; blk_func out 2 (00 clear, 01 load, 10 drop, 11 pull); blk_row out 7; blk_col out 7; blk_in out 3; blk_out in 3, combinational cell read; blk_busy in 1.

Function
REQ-007 SHALL implement FSM states IDLE, FILL, HIT_RD, HIT_WAIT, HIT_WR, DONE.
REQ-008 busy SHALL be 1 in every state except IDLE.
REQ-009 In IDLE, fill_start=1 SHALL go to FILL, zero remaining and cursor (row 0, col 0); fill_start has priority over a simultaneous hit_req, which is dropped.
REQ-010 FILL SHALL issue one LOAD per cycle with blk_busy=0: blk_enable=1, blk_func=01, blk_in=(row mod 7)+1, remaining +1; col advances, wraps COLS-1 -> 0 and increments row.
REQ-011 With blk_busy=1, blk_enable SHALL be 0 and cursor/counters hold.
REQ-012 FILL SHALL return to IDLE after the LOAD at (FILL_ROWS-1, COLS-1); nominal 256 cycles at defaults, remaining=256.
REQ-013 In IDLE, hit_req=1 (no fill_start) SHALL latch hit_row/hit_col and go to HIT_RD.
REQ-014 A latched address with row>=ROWS or col>=COLS SHALL skip to DONE with hit_kind=0, no write.
REQ-015 HIT_RD SHALL drive blk_row/blk_col, blk_enable=0; HIT_WAIT SHALL sample blk_out into hit_kind the next cycle.
REQ-016 hit_kind=0 SHALL go to DONE with no write; nonzero SHALL go to HIT_WR.
REQ-017 HIT_WR SHALL issue one CLEAR (blk_func=00) when blk_busy=0, then score += hit_kind saturating at 16'hFFFF, remaining -1 (floor 0), go to DONE.
REQ-018 DONE SHALL pulse hit_done for exactly one cycle and return to IDLE; hit_kind held until next accepted hit_req.
REQ-019 blk_enable SHALL never be 1 outside FILL and HIT_WR; blk_func/blk_in are don't-care when blk_enable=0.
REQ-020 score SHALL persist across fills; only reset clears it.

Reset
REQ-021 reset low SHALL force IDLE and zero blk_enable, blk_func, blk_row, blk_col, blk_in, hit_done, hit_kind, score, remaining, busy, immediately, including mid-FILL or mid-hit; the aborted operation is not resumed.

Configuration
REQ-022 With BRICK_HARDNESS_EN defined, HIT_WR on hit_kind=7 SHALL issue LOAD with blk_in=6 instead of CLEAR, add 7 to score, leave remaining unchanged.
REQ-023 Without BRICK_HARDNESS_EN, kind 7 SHALL be cleared like any other kind.

Structure
REQ-024 Shared package brick_pkg SHALL hold blk_func encodings (CLEAR, LOAD, DROP, PULL), default ROWS/COLS, kind width 3.
REQ-025 FSM state encoding SHALL be local to brick_hit_engine.
REQ-026 Sub-module brick_cursor (row/col counter with wrap and hold) SHALL be used by FILL.

Verification
REQ-027 Fill with blk_busy=0 -> 256 LOADs, row 0 kind 1, row 7 kind 1, row 6 kind 7; remaining=256, busy drops after 256 cycles.
REQ-028 Hit (3,5) after fill, model blk_out=4 -> one CLEAR at (3,5), score +4, remaining 255, hit_done 1 cycle, hit_kind=4.
REQ-029 Hit (20,5) with blk_out=0 -> no blk_enable, hit_kind=0, score/remaining unchanged.
REQ-030 Hit (30,40) -> DONE without read or write, hit_kind=0.
REQ-031 blk_busy=1 for 10 cycles mid-fill -> no enable, cursor holds, exactly 256 LOADs total; same-cycle fill_start+hit_req -> fill only, no hit_done.
REQ-032 reset low mid-fill -> all outputs 0 immediately; with BRICK_HARDNESS_EN, hit on kind 7 -> LOAD blk_in=6, score +7, remaining unchanged.
